// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared types and helpers for the cartridge SRAM arbiter.
package sram_arbiter_pkg;

    typedef enum logic [2:0] {IDLE, CART_RD, CART_WR, UC_RD, UC_WR} state_e;

    localparam logic SEL_UC   = 1'b0;
    localparam logic SEL_CART = 1'b1;

    function automatic int phase_w(input int access_cycles);
        return $clog2(access_cycles);
    endfunction

endpackage

// File: rtl/sram_strobe_gen.sv
// sram_strobe_gen: decodes {state, phase} into the SRAM control strobes.
module sram_strobe_gen
    import sram_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = 4,
    parameter int PHASE_W       = phase_w(ACCESS_CYCLES)
) (
    input  state_e               state_i,
    input  logic [PHASE_W-1:0]   phase_i,
    output logic                 oe_n_o,
    output logic                 we_n_o,
    output logic                 dout_en_o
);

    // First and last phase of a write are address/data setup and hold.
    localparam logic [PHASE_W-1:0] WE_LAST = PHASE_W'(ACCESS_CYCLES - 2);

    assign dout_en_o = (state_i == CART_WR) || (state_i == UC_WR);
    assign oe_n_o    = !((state_i == CART_RD) || (state_i == UC_RD));
    assign we_n_o    = !(dout_en_o && (phase_i != '0) && (phase_i <= WE_LAST));

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences fixed-length SRAM accesses for the cartridge bus (priority)
// and the microcontroller req/ack port, aligned to phi2 edges.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = 4,
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fi2_rise,
    input  logic              fi2_fall,
    input  logic              cart_req,
    input  logic              cart_we,
    input  logic [ADDR_W-1:0] cart_addr,
    input  logic [DATA_W-1:0] cart_wdata,
    output logic [DATA_W-1:0] cart_rdata,
    output logic              cart_done,
    input  logic              uc_req,
    input  logic              uc_we,
    input  logic [ADDR_W-1:0] uc_addr,
    input  logic [DATA_W-1:0] uc_wdata,
    output logic [DATA_W-1:0] uc_rdata,
    output logic              uc_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dout,
    output logic              ram_dout_en,
    input  logic [DATA_W-1:0] ram_din,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              busy
);

    localparam int                 PHASE_W = phase_w(ACCESS_CYCLES);
    localparam logic [PHASE_W-1:0] LAST    = PHASE_W'(ACCESS_CYCLES - 1);

    state_e              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [DATA_W-1:0]   cart_rdata_q, cart_rdata_d, uc_rdata_q, uc_rdata_d;
    logic                cart_done_q, cart_done_d, uc_ack_q, uc_ack_d;
    logic                cart_start, uc_start, last, sel;

    // A simultaneous rise and fall counts as a rise, so the uC never starts then.
    assign cart_start = fi2_rise & cart_req;
    assign uc_start   = fi2_fall & ~fi2_rise & uc_req & ~uc_ack_q;
    assign last       = phase_q == LAST;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q + 1'b1;
        cart_done_d  = 1'b0;
        uc_ack_d     = uc_ack_q & uc_req;
        cart_rdata_d = cart_rdata_q;
        uc_rdata_d   = uc_rdata_q;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (cart_start)
                    state_d = cart_we ? CART_WR : CART_RD;
                else if (uc_start)
                    state_d = uc_we ? UC_WR : UC_RD;
            end
            CART_RD, CART_WR: begin
                if (last) begin
                    state_d     = IDLE;
                    phase_d     = '0;
                    cart_done_d = 1'b1;
                    if (state_q == CART_RD) cart_rdata_d = ram_din;
                end
            end
            UC_RD, UC_WR: begin
                // Cart preempts: the uC access is dropped and retried on a later fall.
                if (cart_start) begin
                    state_d = cart_we ? CART_WR : CART_RD;
                    phase_d = '0;
                end else if (last) begin
                    state_d  = IDLE;
                    phase_d  = '0;
                    uc_ack_d = 1'b1;
                    if (state_q == UC_RD) uc_rdata_d = ram_din;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            cart_done_q  <= 1'b0;
            uc_ack_q     <= 1'b0;
            cart_rdata_q <= '0;
            uc_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cart_done_q  <= cart_done_d;
            uc_ack_q     <= uc_ack_d;
            cart_rdata_q <= cart_rdata_d;
            uc_rdata_q   <= uc_rdata_d;
        end
    end

    assign sel        = ((state_q == CART_RD) || (state_q == CART_WR)) ? SEL_CART : SEL_UC;
    assign ram_addr   = (sel == SEL_CART) ? cart_addr : uc_addr;
    assign ram_dout   = (sel == SEL_CART) ? cart_wdata : uc_wdata;
    assign busy       = state_q != IDLE;
    assign cart_done  = cart_done_q;
    assign uc_ack     = uc_ack_q;
    assign cart_rdata = cart_rdata_q;
    assign uc_rdata   = uc_rdata_q;

    sram_strobe_gen #(
        .ACCESS_CYCLES (ACCESS_CYCLES),
        .PHASE_W       (PHASE_W)
    ) u_strobe (
        .state_i   (state_q),
        .phase_i   (phase_q),
        .oe_n_o    (ram_oe_n),
        .we_n_o    (ram_we_n),
        .dout_en_o (ram_dout_en)
    );

endmodule
